// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse key schedule.
//   word_t    : 32-bit key-schedule word.
//   state_e   : schedule FSM states (idle, emitting keys, completion pulse).
//   aes_rcon  : round constant lookup, Rcon[1..10]; 0 outside that range.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StEmit = 2'd1,
        StFin  = 2'd2
    } state_e;

    localparam logic [3:0] LastRound = 4'd10;

    function automatic logic [7:0] aes_rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
//   in_byte  : input byte
//   out_byte : S-box substitution of in_byte
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Element 0 is the leftmost byte of the concatenation.
    localparam logic [0:255][7:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SboxTable[in_byte];

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 inverse key schedule: starting from the round-10 key, emits the
// round keys 10 down to 0 over a valid/ready handshake, one key per cycle
// when the consumer is always ready.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, last_key     : begin a schedule from last_key (sampled in idle)
//   key_valid/key_ready : handshake for round_key/round_idx
//   round_key/round_idx : current round key and its round number
//   busy                : schedule in progress
//   done                : one-cycle pulse after round 0 is accepted
// Build option: define AES_KEY_ZEROIZE_EN to clear round_key on completion
// and keep it cleared while idle.
module aes_inv_key_sched
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic         key_valid,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;

    word_t w0, w1, w2, w3;
    word_t p0, p1, p2, p3;
    word_t rot_word, sub_word;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // Undo the forward expansion: recover the previous round's words.
    assign p3       = w3 ^ w2;
    assign p2       = w2 ^ w1;
    assign p1       = w1 ^ w0;
    assign rot_word = {p3[23:0], p3[31:24]};
    assign p0       = w0 ^ sub_word ^ {aes_rcon(idx_q), 24'h0};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*i +: 8]),
            .out_byte (sub_word[8*i +: 8])
        );
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d   = last_key;
                    idx_d   = LastRound;
                    state_d = StEmit;
                end else begin
`ifdef AES_KEY_ZEROIZE_EN
                    key_d = '0;
`endif
                end
            end
            StEmit: begin
                if (key_ready) begin
                    if (idx_q == 4'd0) begin
                        state_d = StFin;
`ifdef AES_KEY_ZEROIZE_EN
                        key_d = '0;
`endif
                    end else begin
                        key_d = {p0, p1, p2, p3};
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            key_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
        end
    end

    // All outputs decode registered state only; none looks at key_ready.
    assign key_valid = (state_q == StEmit);
    assign busy      = (state_q == StEmit);
    assign done      = (state_q == StFin);
    assign round_key = key_q;
    assign round_idx = idx_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
module tb_aes_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] last_key;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] got_keys [0:10];
    logic [127:0] ref_keys [0:10];
    int           keys_seen;
    int           dones_seen;
    int           done_cyc;
    logic [127:0] final_exp;

    localparam logic [127:0] KeyR10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KeyR9   = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] KeyR0   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KeyAlt  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    always #5 clk = ~clk;

    aes_inv_key_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .last_key  (last_key),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    // Reference S-box for the forward-expansion model.
    localparam logic [0:255][7:0] SboxRef = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] ref_sub_word(input logic [31:0] w);
        return {SboxRef[w[31:24]], SboxRef[w[23:16]], SboxRef[w[15:8]], SboxRef[w[7:0]]};
    endfunction

    function automatic logic [7:0] ref_rcon(input int r);
        logic [7:0] tbl [1:10];
        tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        return tbl[r];
    endfunction

    // Forward AES-128 key expansion from a round-0 key.
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = ref_sub_word({t[23:0], t[31:24]}) ^ {ref_rcon(i / 4), 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full schedule. rand_ready: 1-0-0-1 then random ready; hammer: hold
    // start high through EMIT and FIN with a different last_key presented.
    task automatic run_sched(input logic [127:0] lk, input bit rand_ready, input bit hammer);
        int           r;
        bit           kr;
        bit           prev_hs;
        logic [127:0] prev_key;
        r          = 10;
        keys_seen  = 0;
        dones_seen = 0;
        done_cyc   = -1;
        prev_hs    = 1'b1;
        prev_key   = '0;
        for (int i = 0; i <= 10; i++) got_keys[i] = 'x;
        last_key  = lk;
        start     = 1'b1;
        key_ready = 1'b1;
        @(posedge clk); #1;
        if (!hammer) start = 1'b0;
        last_key = ~lk;
        chk("first_key", round_key, lk);
        for (int cyc = 0; cyc < 200 && dones_seen == 0; cyc++) begin
            if (done) begin
                dones_seen++;
                done_cyc = cyc;
                chk("fin_busy", busy, 0);
                chk("fin_valid", key_valid, 0);
            end else begin
                chk("emit_valid", key_valid, 1);
                chk("emit_busy", busy, 1);
                chk("round_idx", round_idx, r);
                if (!prev_hs) chk("hold_key", round_key, prev_key);
                if (r >= 0 && r <= 10) got_keys[r] = round_key;
                if (!rand_ready) kr = 1'b1;
                else if (cyc < 4) kr = (cyc % 4 == 0) || (cyc % 4 == 3);
                else kr = 1'($urandom_range(0, 1));
                key_ready = kr;
                prev_hs   = kr;
                prev_key  = round_key;
                if (kr) begin
                    keys_seen++;
                    r--;
                end
            end
            @(posedge clk); #1;
        end
        chk("done_count", dones_seen, 1);
        chk("key_count", keys_seen, 11);
        // Now in idle; start (if hammered) was still high through FIN.
        chk("idle_valid", key_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        start     = 1'b0;
        key_ready = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        key_ready = 1'b0;
        last_key  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", key_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_idx", round_idx, 0);
        chk("rst_key", round_key, 0);
        rst_n = 1'b1;

        // Full-throughput schedule right after reset release.
        expand(KeyR0);
        run_sched(KeyR10, 1'b0, 1'b0);
        chk("latency_11", done_cyc, 11);
        chk("key_idx9", got_keys[9], KeyR9);
        chk("key_idx0", got_keys[0], KeyR0);
        for (int i = 0; i <= 10; i++) chk($sformatf("tput_key%0d", i), got_keys[i], ref_keys[i]);
`ifdef AES_KEY_ZEROIZE_EN
        final_exp = '0;
`else
        final_exp = KeyR0;
`endif
        chk("final_key", round_key, final_exp);

        // Back-pressured schedule.
        run_sched(KeyR10, 1'b1, 1'b0);
        for (int i = 0; i <= 10; i++) chk($sformatf("bp_key%0d", i), got_keys[i], ref_keys[i]);

        // Start held high during the schedule.
        run_sched(KeyR10, 1'b0, 1'b1);
        for (int i = 0; i <= 10; i++) chk($sformatf("hs_key%0d", i), got_keys[i], ref_keys[i]);
        chk("hs_final_key", round_key, final_exp);

        // Reset in the middle of a schedule.
        last_key  = KeyAlt;
        start     = 1'b1;
        key_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && round_idx != 4'd5; c++) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_idx", round_idx, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_idx", round_idx, 0);
        chk("mid_rst_key", round_key, 0);
        @(posedge clk); #1;
        chk("mid_rst_hold_idx", round_idx, 0);
        chk("mid_rst_hold_key", round_key, 0);
        rst_n = 1'b1;

        // Fresh schedule from an all-zero round-10 key; forward-expand the
        // recovered round-0 key and require it to reproduce every round.
        run_sched(128'h0, 1'b0, 1'b0);
        expand(got_keys[0]);
        chk("zero_ref_r10", ref_keys[10], 128'h0);
        for (int i = 0; i <= 10; i++) chk($sformatf("zero_key%0d", i), got_keys[i], ref_keys[i]);
`ifdef AES_KEY_ZEROIZE_EN
        final_exp = '0;
`else
        final_exp = got_keys[0];
`endif
        chk("zero_final_key", round_key, final_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_sched.md
AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock; sole clock domain.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  input  1  request to begin a schedule; sampled only in IDLE.
REQ-004 SHALL have ports: last_key  input  128  round-10 key, MSB = byte 0; captured on accepted start.
REQ-005 SHALL have ports: key_valid  output  1  round_key/round_idx hold a valid key.
REQ-006 SHALL have ports: key_ready  input  1  consumer accepts the key when high with key_valid.
REQ-007 SHALL have ports: round_key  output  128  current round key, registered.
REQ-008 SHALL have ports: round_idx  output  4  round number of round_key, 10 down to 0.
REQ-009 SHALL have ports: busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
REQ-010 SHALL have ports: done  output  1  one-cycle pulse after round 0 is accepted.

Function
REQ-011 SHALL be an FSM with states IDLE, EMIT, FIN.
REQ-012 SHALL, in IDLE with start=1: load last_key into round_key, set round_idx=10, and enter EMIT; key_valid=1 from the next cycle (latency 1).
REQ-013 SHALL, in EMIT, hold round_key, round_idx and key_valid stable until key_valid&&key_ready (handshake).
REQ-014 SHALL, on handshake with round_idx=r>0: replace the words w0..w3 (w0 = bits 127:96) with p3=w3^w2, p2=w2^w1, p1=w1^w0, p0=w0^SubWord(RotWord(p3))^{Rcon[r],24'h0}, and set round_idx=r-1 in the same edge; key_valid stays 1, so sustained throughput is 1 key/cycle.
REQ-015 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36; RotWord = rotate left one byte; SubWord = forward S-box per byte.
REQ-016 SHALL, on handshake with round_idx=0: drop key_valid and enter FIN.
REQ-017 SHALL, in FIN: pulse done for exactly one cycle, drop busy, and return to IDLE; start in FIN is ignored.
REQ-018 SHALL ignore start in EMIT and FIN; it SHALL NOT restart or corrupt a schedule in flight.
REQ-019 SHALL NOT combinationally depend on key_ready for key_valid (no valid-after-ready).
REQ-020 SHALL emit exactly 11 keys per start; round_idx SHALL never wrap below 0.

Reset
REQ-021 SHALL, on rst_n low at any time including mid-EMIT: go to IDLE with key_valid=0, busy=0, done=0, round_idx=0, round_key=0; a partial schedule is abandoned.
REQ-022 SHALL accept a new start the first clock after reset release.

Configuration
REQ-023 SHALL implement macro AES_KEY_ZEROIZE_EN: when defined, round_key SHALL be cleared to 0 on the same edge that enters FIN and held at 0 while IDLE; when undefined, round_key SHALL retain the round-0 key after completion.

Structure
REQ-024 SHALL take the word typedef (32-bit), the Rcon table, and the FSM state enum from shared package aes_pkg.
REQ-025 SHALL instantiate sub-module aes_sbox (combinational 8-bit forward S-box) four times for SubWord.

Verification
REQ-026 SHALL check: last_key=13111d7fe3944a17f307a78b4d2b30c5, start, key_ready=1 -> keys idx 10..0 on 11 consecutive cycles; idx 9 = 549932d1f08557681093ed9cbe2c974e; idx 0 = 000102030405060708090a0b0c0d0e0f; done pulses once.
REQ-027 SHALL check: same run with key_ready toggling 1-0-0-1 pseudo-randomly -> identical key sequence, round_key stable while key_ready=0.
REQ-028 SHALL check: start asserted every cycle during EMIT -> exactly 11 keys, single done, no restart.
REQ-029 SHALL check: rst_n low while round_idx=5 -> next cycle all outputs 0; a fresh start then yields idx 10 = new last_key.
REQ-030 SHALL check: with AES_KEY_ZEROIZE_EN defined, round_key=0 after done; without it, round_key=000102030405060708090a0b0c0d0e0f after done.
REQ-031 SHALL check: last_key=all-zero round-10 key of a random reference key -> round 0 matches a software model key schedule.
